// File: rtl/neuron_mac_8bit.sv
// -----------------------------------------------------------------------------
// neuron_mac_8bit
//
// Signed multiply-accumulate stage feeding the 8-bit sigmoid activation.
// Consumes a stream of (activation, weight) beats in Q4.4, accumulates their
// Q8.8 products in a saturating ACC_W-bit accumulator and, on the beat marked
// last, forms one clamped signed 8-bit Q4.4 pre-activation per neuron.
//
// Optional feature macro: NEURON_BIAS_EN
//   defined   : 8-bit bias register with bias_load/bias_in ports; the bias is
//               added (scaled to Q.8) before the final shift.
//   undefined : bias ports absent, bias is constant zero.
//
// Parameters
//   ACC_W  accumulator width, signed Q(ACC_W-8).8, legal 16..32
//   FRAC   fractional bits of the 8-bit operands and result (4 -> Q4.4)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat offered
//   in_ready   input beat may be accepted (low while a result is held)
//   in_x       signed activation, Q4.4
//   in_w       signed weight, Q4.4
//   in_last    final beat of the current neuron
//   bias_load  load bias_in into the bias register (NEURON_BIAS_EN only)
//   bias_in    signed bias, Q4.4 (NEURON_BIAS_EN only)
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_data   signed saturated result, Q4.4
//   out_sat    result clipped or accumulator saturated during this neuron
//   dbg_state  current FSM state (0 IDLE, 1 ACC, 2 OUT)
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high; a valid source holds its payload stable until
// that edge, and ready never depends combinationally on valid.
// -----------------------------------------------------------------------------
module neuron_mac_8bit #(
  parameter int ACC_W = 20,
  parameter int FRAC  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_w,
  input  logic       in_last,
`ifdef NEURON_BIAS_EN
  input  logic       bias_load,
  input  logic [7:0] bias_in,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sat,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             accsat_q, accsat_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic [7:0]       bias_q;

  logic             beat;
  logic [15:0]      x_ext, w_ext, prod;
  logic [ACC_W:0]   sum_w;
  logic             acc_ovf;
  logic [ACC_W-1:0] acc_nx;
  logic             accsat_nx;
  logic [ACC_W+1:0] s_w;
  logic signed [ACC_W+1:0] r_w;
  logic             r_fits;
  logic [7:0]       res;

  assign in_ready  = (state_q != S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign dbg_state = state_q;
  assign beat      = in_valid & in_ready;

  // Operands are sign-extended to 16 bits; the low 16 bits of the unsigned
  // product equal the signed product, which always fits (max |p| = 2^14).
  assign x_ext = {{8{in_x[7]}}, in_x};
  assign w_ext = {{8{in_w[7]}}, in_w};
  assign prod  = x_ext * w_ext;

  // One guard bit detects overflow of acc + p; clamp to the extreme of the
  // sign the true sum would have had.
  assign sum_w   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){prod[15]}}, prod};
  assign acc_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  always_comb begin
    acc_nx = sum_w[ACC_W-1:0];
    if (acc_ovf) begin
      acc_nx = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
  assign accsat_nx = accsat_q | acc_ovf;

`ifdef NEURON_BIAS_EN
  // A load on the same edge as the last beat lands after the result has been
  // formed from the old value, so the old bias applies to that neuron.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q <= 8'h00;
    end else if (bias_load) begin
      bias_q <= bias_in;
    end
  end
`else
  assign bias_q = 8'h00;
`endif

  // Bias (Q4.4) is shifted up by FRAC to line up with the Q.8 accumulator;
  // two extra bits cover the worst-case sum. Arithmetic shift floors.
  assign s_w    = {{2{acc_nx[ACC_W-1]}}, acc_nx}
                + {{(ACC_W+2-8-FRAC){bias_q[7]}}, bias_q, {FRAC{1'b0}}};
  assign r_w    = $signed(s_w) >>> FRAC;
  assign r_fits = (r_w[ACC_W+1:7] == '0) || (r_w[ACC_W+1:7] == '1);
  assign res    = r_fits ? r_w[7:0] : (r_w[ACC_W+1] ? 8'h80 : 8'h7F);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    accsat_d   = accsat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (beat) begin
          acc_d    = acc_nx;
          accsat_d = accsat_nx;
          if (in_last) begin
            state_d    = S_OUT;
            out_data_d = res;
            out_sat_d  = accsat_nx | ~r_fits;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d  = S_IDLE;
          acc_d    = '0;
          accsat_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        acc_d    = '0;
        accsat_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      accsat_q   <= 1'b0;
      out_data_q <= 8'h00;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      accsat_q   <= accsat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_8bit.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac_8bit
//
// Directed cases followed by randomized neurons against a reference model
// built from plain integer arithmetic. Expected results are queued when the
// last beat is issued; a negedge monitor pops and compares on each output
// handshake, and also checks hold stability and the post-handshake bubble.
// -----------------------------------------------------------------------------
module tb_neuron_mac_8bit;

  localparam int  ACC_W   = 20;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_x = 8'h00;
  logic [7:0] in_w = 8'h00;
  logic       in_last = 1'b0;
`ifdef NEURON_BIAS_EN
  logic       bias_load = 1'b0;
  logic [7:0] bias_in = 8'h00;
`endif
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_sat;
  logic [1:0] dbg_state;

  neuron_mac_8bit #(.ACC_W(ACC_W), .FRAC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
`ifdef NEURON_BIAS_EN
    .bias_load (bias_load),
    .bias_in   (bias_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];   // {sat, data}

  longint     m_acc  = 0;
  bit         m_sat  = 0;
  logic [7:0] m_bias = 8'h00;

  int rdy_mode = 0;       // 0 always ready, 1 never ready, 2 random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_beat(input logic [7:0] x, input logic [7:0] w);
    longint p;
    p = longint'($signed(x)) * longint'($signed(w));
    m_acc = m_acc + p;
    if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_sat = 1; end
    if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_sat = 1; end
  endfunction

  function automatic logic [8:0] model_result();
    longint s, r;
    logic [7:0] d;
    bit clip;
    s = m_acc + longint'($signed(m_bias)) * 16;
    r = s >>> 4;
    clip = 0;
    if (r > 127)       begin d = 8'h7F; clip = 1; end
    else if (r < -128) begin d = 8'h80; clip = 1; end
    else               d = r[7:0];
    return {(m_sat | clip), d};
  endfunction

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [7:0] x, input logic [7:0] w, input logic last,
                           input logic do_bias, input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_w = w; in_last = last;
    while (!in_ready && guard < 300) begin @(negedge clk); guard++; end
    check("beat_accept_window", 32'(in_ready), 32'd1);
    if (!in_ready) begin in_valid = 1'b0; return; end
`ifdef NEURON_BIAS_EN
    if (do_bias) begin bias_load = 1'b1; bias_in = b; end
`endif
    model_beat(x, w);
    if (last) begin
      exp_q.push_back(model_result());
      m_acc = 0; m_sat = 0;
    end
`ifdef NEURON_BIAS_EN
    if (do_bias) m_bias = b;
`else
    if (do_bias && b != 8'h00) m_bias = 8'h00;  // no bias register in this build
`endif
    @(posedge clk); #1;
`ifdef NEURON_BIAS_EN
    bias_load = 1'b0;
`endif
    if (last) begin
      check("latency_out_valid", 32'(out_valid), 32'd1);
      check("busy_in_ready", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic idle_input();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic load_bias(input logic [7:0] b);
`ifdef NEURON_BIAS_EN
    @(negedge clk);
    bias_load = 1'b1; bias_in = b;
    @(posedge clk); #1;
    bias_load = 1'b0;
    m_bias = b;
`else
    if (b != 8'h00) @(negedge clk);
`endif
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin @(negedge clk); guard++; end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  bit         hold_v  = 0;
  logic [7:0] hold_d;
  logic       hold_s;
  bit         hs_prev = 0;

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
`ifdef NEURON_BIAS_EN
    bias_load = 1'b0;
`endif
    exp_q.delete();
    hold_v = 0; hs_prev = 0;
    m_acc = 0; m_sat = 0; m_bias = 8'h00;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_prev) begin
        check("bubble_in_ready", 32'(in_ready), 32'd1);
        check("bubble_out_valid", 32'(out_valid), 32'd0);
        hs_prev = 0;
      end
      if (hold_v) begin
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_out_data", 32'(out_data), 32'(hold_d));
        check("hold_out_sat", 32'(out_sat), 32'(hold_s));
        hold_v = 0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(exp_q.size()), 32'd1);
        end else if (out_ready) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[7:0]));
          check("out_sat", 32'(out_sat), 32'(e[8]));
          hs_prev = 1;
        end else begin
          hold_v = 1; hold_d = out_data; hold_s = out_sat;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // 1.0 * 2.0 -> 2.0
    send_beat(8'h10, 8'h20, 1'b1, 1'b0, 8'h00);
    // large positive sum clips
    for (int i = 0; i < 4; i++) send_beat(8'h7F, 8'h7F, (i == 3), 1'b0, 8'h00);
    // large negative product clips
    send_beat(8'h80, 8'h7F, 1'b1, 1'b0, 8'h00);
    // floor of -1/16
    send_beat(8'hFF, 8'h01, 1'b1, 1'b0, 8'h00);
    // accumulator saturation then flag cleared for next neuron
    for (int i = 0; i < 40; i++) send_beat(8'h80, 8'h80, (i == 39), 1'b0, 8'h00);
    send_beat(8'h10, 8'h10, 1'b1, 1'b0, 8'h00);
    idle_input();
    wait_drain();

    // bias: load with last beat uses old bias, later neuron sees new bias
    send_beat(8'h00, 8'h00, 1'b1, 1'b1, 8'h10);
    send_beat(8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    load_bias(8'hE8);
    send_beat(8'h18, 8'h20, 1'b1, 1'b0, 8'h00);
    load_bias(8'h00);
    idle_input();
    wait_drain();

    // backpressure: result held 5 cycles
    rdy_mode = 1;
    @(posedge clk); #2;
    send_beat(8'h30, 8'h11, 1'b1, 1'b0, 8'h00);
    idle_input();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    rdy_mode = 0;
    wait_drain();

    // reset mid-neuron discards partial sum
    send_beat(8'h7F, 8'h40, 1'b0, 1'b0, 8'h00);
    send_beat(8'h7F, 8'h40, 1'b0, 1'b0, 8'h00);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_out_after_rst", 32'(out_valid), 32'd0);
    end
    send_beat(8'h20, 8'h08, 1'b1, 1'b0, 8'h00);
    idle_input();
    wait_drain();

    // reset while a result is held
    rdy_mode = 1;
    @(posedge clk); #2;
    send_beat(8'h20, 8'h20, 1'b1, 1'b0, 8'h00);
    idle_input();
    @(negedge clk);
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_out_after_rst_out", 32'(out_valid), 32'd0);
    end
    send_beat(8'hF0, 8'h30, 1'b1, 1'b0, 8'h00);

    // randomized neurons with random backpressure and bias updates
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      int len;
      int kind;
      len  = $urandom_range(1, 8);
      kind = $urandom_range(0, 4);
      if (kind == 4) len = $urandom_range(20, 45);
      for (int b = 0; b < len; b++) begin
        logic [7:0] x, w, bb;
        logic       db;
        case (kind)
          0:       begin x = 8'($urandom_range(0, 255)); w = 8'($urandom_range(0, 255)); end
          1:       begin x = 8'($urandom_range(0, 31)) - 8'd16; w = 8'($urandom_range(0, 31)) - 8'd16; end
          2:       begin x = 8'h7F; w = 8'($urandom_range(0, 1) ? 8'h7F : 8'h80); end
          3:       begin x = 8'($urandom_range(0, 255)); w = 8'h01; end
          default: begin x = 8'h80; w = 8'($urandom_range(0, 1) ? 8'h80 : 8'h7F); end
        endcase
        db = (b == len - 1) && ($urandom_range(0, 3) == 0);
        bb = 8'($urandom_range(0, 255));
        send_beat(x, w, (b == len - 1), db, bb);
      end
      if ($urandom_range(0, 5) == 0) idle_input();
    end
    idle_input();
    rdy_mode = 0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
